id_ex_reg: RTL and testbench

ID/EX pipeline register of the pipelined MIPS datapath. It captures the decode-stage results one cycle after decode:
- register-file read data
- the 32-bit sign-extended immediate from the ID-stage sign extender
- register addresses, PC+4 and control bits

It presents them to the EX stage and supports hazard-unit stall (hold) and flush (bubble). It also bypasses same-cycle write-back data so EX never sees a stale register value, and keeps a saturating count of inserted bubbles for performance monitoring.

---
 rtl/id_ex_reg_if.sv | 66 ++++++
 rtl/id_ex_reg.sv | 104 ++++++++++
 tb/tb_id_ex_reg.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: decode-stage results and WB bypass inputs in, EX-stage copies out.
// No latency of its own; carries no flow control beyond the hazard-unit stall/flush levels.
// master = ID/hazard/WB side driving *_i, slave = the pipeline register driving *_o.
interface id_ex_reg_if #(
  parameter int CNT_W = 8
);
  logic             stall_i;
  logic             flush_i;
  logic             valid_i;
  logic [31:0]      pc_plus4_i;
  logic [31:0]      rs_data_i;
  logic [31:0]      rt_data_i;
  logic [31:0]      imm_ext_i;
  logic [4:0]       rs_addr_i;
  logic [4:0]       rt_addr_i;
  logic [4:0]       rd_addr_i;
  logic             reg_write_i;
  logic             mem_to_reg_i;
  logic             mem_read_i;
  logic             mem_write_i;
  logic             branch_i;
  logic             alu_src_i;
  logic             reg_dst_i;
  logic [2:0]       alu_op_i;
  logic             wb_reg_write_i;
  logic [4:0]       wb_addr_i;
  logic [31:0]      wb_data_i;

  logic             valid_o;
  logic [31:0]      pc_plus4_o;
  logic [31:0]      rs_data_o;
  logic [31:0]      rt_data_o;
  logic [31:0]      imm_ext_o;
  logic [4:0]       rs_addr_o;
  logic [4:0]       rt_addr_o;
  logic [4:0]       rd_addr_o;
  logic             reg_write_o;
  logic             mem_to_reg_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             branch_o;
  logic             alu_src_o;
  logic             reg_dst_o;
  logic [2:0]       alu_op_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i,
           rs_addr_i, rt_addr_i, rd_addr_i, reg_write_i, mem_to_reg_i, mem_read_i,
           mem_write_i, branch_i, alu_src_i, reg_dst_i, alu_op_i,
           wb_reg_write_i, wb_addr_i, wb_data_i,
    input  valid_o, pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o, rs_addr_o, rt_addr_o,
           rd_addr_o, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, branch_o,
           alu_src_o, reg_dst_o, alu_op_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, pc_plus4_i, rs_data_i, rt_data_i, imm_ext_i,
           rs_addr_i, rt_addr_i, rd_addr_i, reg_write_i, mem_to_reg_i, mem_read_i,
           mem_write_i, branch_i, alu_src_i, reg_dst_i, alu_op_i,
           wb_reg_write_i, wb_addr_i, wb_data_i,
    output valid_o, pc_plus4_o, rs_data_o, rt_data_o, imm_ext_o, rs_addr_o, rt_addr_o,
           rd_addr_o, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, branch_o,
           alu_src_o, reg_dst_o, alu_op_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with WB bypass, hazard stall/flush and a saturating bubble counter.
// Latency 1 cycle; every output is registered.
// stall_i holds contents (WB writes still land), flush_i inserts a bubble and wins over stall_i.
module id_ex_reg #(
  parameter int CNT_W = 8
) (
  input logic         clk_i,
  input logic         rst_i,
  id_ex_reg_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  alu_op;
  } stage_t;

  stage_t           q;
  stage_t           d_load;
  logic [CNT_W-1:0] bubble_cnt;

  logic wb_ok;
  logic rs_hit_ld, rt_hit_ld;
  logic rs_hit_st, rt_hit_st;

  // $0 is hardwired, so a WB write to it must never be forwarded.
  assign wb_ok     = bus.wb_reg_write_i && (bus.wb_addr_i != 5'd0);
  assign rs_hit_ld = wb_ok && (bus.wb_addr_i == bus.rs_addr_i);
  assign rt_hit_ld = wb_ok && (bus.wb_addr_i == bus.rt_addr_i);
  assign rs_hit_st = wb_ok && q.valid && (bus.wb_addr_i == q.rs_addr);
  assign rt_hit_st = wb_ok && q.valid && (bus.wb_addr_i == q.rt_addr);

  always_comb begin
    d_load          = '0;
    d_load.valid    = bus.valid_i;
    d_load.pc_plus4 = bus.pc_plus4_i;
    d_load.rs_data  = rs_hit_ld ? bus.wb_data_i : bus.rs_data_i;
    d_load.rt_data  = rt_hit_ld ? bus.wb_data_i : bus.rt_data_i;
    d_load.imm_ext  = bus.imm_ext_i;
    d_load.rs_addr  = bus.rs_addr_i;
    d_load.rt_addr  = bus.rt_addr_i;
    d_load.rd_addr  = bus.rd_addr_i;
    if (bus.valid_i) begin
      d_load.reg_write  = bus.reg_write_i;
      d_load.mem_to_reg = bus.mem_to_reg_i;
      d_load.mem_read   = bus.mem_read_i;
      d_load.mem_write  = bus.mem_write_i;
      d_load.branch     = bus.branch_i;
      d_load.alu_src    = bus.alu_src_i;
      d_load.reg_dst    = bus.reg_dst_i;
      d_load.alu_op     = bus.alu_op_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q          <= '0;
      bubble_cnt <= '0;
    end else if (bus.flush_i) begin
      q <= '0;
      if (bubble_cnt != {CNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else if (bus.stall_i) begin
      // Held instruction still picks up register writes retiring in WB.
      if (rs_hit_st) q.rs_data <= bus.wb_data_i;
      if (rt_hit_st) q.rt_data <= bus.wb_data_i;
    end else begin
      q <= d_load;
    end
  end

  assign bus.valid_o      = q.valid;
  assign bus.pc_plus4_o   = q.pc_plus4;
  assign bus.rs_data_o    = q.rs_data;
  assign bus.rt_data_o    = q.rt_data;
  assign bus.imm_ext_o    = q.imm_ext;
  assign bus.rs_addr_o    = q.rs_addr;
  assign bus.rt_addr_o    = q.rt_addr;
  assign bus.rd_addr_o    = q.rd_addr;
  assign bus.reg_write_o  = q.reg_write;
  assign bus.mem_to_reg_o = q.mem_to_reg;
  assign bus.mem_read_o   = q.mem_read;
  assign bus.mem_write_o  = q.mem_write;
  assign bus.branch_o     = q.branch;
  assign bus.alu_src_o    = q.alu_src;
  assign bus.reg_dst_o    = q.reg_dst;
  assign bus.alu_op_o     = q.alu_op;
  assign bus.bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed vector table, hand sequences for stall/flush/reset, random vs model.
// Latency under test is 1 cycle; outputs are sampled 1 time unit after the rising edge.
// Stall/flush are driven as plain levels alongside the data inputs.
module tb_id_ex_reg;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  id_ex_reg_if #(.CNT_W(CW)) bus();
  id_ex_reg #(.CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  // ctrl = {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op[2:0]}
  typedef struct packed {
    logic        stall, flush, valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [9:0]  ctrl;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
  } in_t;

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc, rs_data, rt_data, imm;
    logic [4:0]    rs_addr, rt_addr, rd_addr;
    logic [9:0]    ctrl;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct {
    string n;
    in_t   i;
    out_t  e;
  } vec_t;

  vec_t tbl[$];
  out_t mdl = '0;

  function automatic in_t mk(input logic fl, input logic vl, input logic [31:0] pc,
                             input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                             input logic [4:0] rsa, input logic [4:0] rta, input logic [4:0] rda,
                             input logic [9:0] ctrl, input logic we, input logic [4:0] wa,
                             input logic [31:0] wd);
    in_t v;
    v = '{stall: 1'b0, flush: fl, valid: vl, pc: pc, rs_data: rsd, rt_data: rtd, imm: imm,
          rs_addr: rsa, rt_addr: rta, rd_addr: rda, ctrl: ctrl, wb_we: we, wb_addr: wa, wb_data: wd};
    return v;
  endfunction

  function automatic out_t mo(input logic vl, input logic [31:0] pc, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic [31:0] imm, input logic [4:0] rsa,
                              input logic [4:0] rta, input logic [4:0] rda, input logic [9:0] ctrl,
                              input int cnt);
    out_t o;
    o = '{valid: vl, pc: pc, rs_data: rsd, rt_data: rtd, imm: imm, rs_addr: rsa, rt_addr: rta,
          rd_addr: rda, ctrl: ctrl, cnt: CW'(cnt)};
    return o;
  endfunction

  // Reference: one edge of the stage expressed directly from the stall/flush/load/bypass rules.
  function automatic out_t model_next(input out_t c, input in_t v);
    out_t n;
    bit   wb_ok;
    int   k;
    n = c;
    wb_ok = v.wb_we && (v.wb_addr != 5'd0);
    if (v.flush) begin
      k = int'(c.cnt) + 1;
      if (k > CMAX) k = CMAX;
      n = '0;
      n.cnt = CW'(k);
    end else if (v.stall) begin
      if (c.valid && wb_ok && v.wb_addr == c.rs_addr) n.rs_data = v.wb_data;
      if (c.valid && wb_ok && v.wb_addr == c.rt_addr) n.rt_data = v.wb_data;
    end else begin
      n.valid   = v.valid;
      n.pc      = v.pc;
      n.imm     = v.imm;
      n.rs_addr = v.rs_addr;
      n.rt_addr = v.rt_addr;
      n.rd_addr = v.rd_addr;
      n.ctrl    = v.valid ? v.ctrl : 10'd0;
      n.rs_data = (wb_ok && v.wb_addr == v.rs_addr) ? v.wb_data : v.rs_data;
      n.rt_data = (wb_ok && v.wb_addr == v.rt_addr) ? v.wb_data : v.rt_data;
    end
    return n;
  endfunction

  task automatic add(input string n, input in_t i, input out_t e);
    vec_t t;
    t.n = n; t.i = i; t.e = e;
    tbl.push_back(t);
  endtask

  task automatic drive(input in_t v);
    bus.stall_i = v.stall;  bus.flush_i = v.flush;  bus.valid_i = v.valid;
    bus.pc_plus4_i = v.pc;  bus.rs_data_i = v.rs_data;  bus.rt_data_i = v.rt_data;
    bus.imm_ext_i = v.imm;  bus.rs_addr_i = v.rs_addr;  bus.rt_addr_i = v.rt_addr;
    bus.rd_addr_i = v.rd_addr;
    {bus.reg_write_i, bus.mem_to_reg_i, bus.mem_read_i, bus.mem_write_i, bus.branch_i,
     bus.alu_src_i, bus.reg_dst_i, bus.alu_op_i} = v.ctrl;
    bus.wb_reg_write_i = v.wb_we;  bus.wb_addr_i = v.wb_addr;  bus.wb_data_i = v.wb_data;
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.valid = bus.valid_o;  o.pc = bus.pc_plus4_o;  o.rs_data = bus.rs_data_o;
    o.rt_data = bus.rt_data_o;  o.imm = bus.imm_ext_o;  o.rs_addr = bus.rs_addr_o;
    o.rt_addr = bus.rt_addr_o;  o.rd_addr = bus.rd_addr_o;
    o.ctrl = {bus.reg_write_o, bus.mem_to_reg_o, bus.mem_read_o, bus.mem_write_o, bus.branch_o,
              bus.alu_src_o, bus.reg_dst_o, bus.alu_op_o};
    o.cnt = bus.bubble_cnt_o;
    return o;
  endfunction

  task automatic check(input string nm, input out_t exp);
    out_t a;
    a = dut_out();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, a, exp);
    end
  endtask

  task automatic cycle(input in_t v);
    drive(v);
    @(posedge clk);
    #1;
    mdl = model_next(mdl, v);
  endtask

  // Reset is raised between edges so its effect is visible before any clock.
  task automatic async_reset(input string nm);
    rst = 1'b1;
    #2;
    mdl = '0;
    check({nm, "_now"}, '0);
    @(posedge clk);
    #1;
    check({nm, "_held"}, '0);
    rst = 1'b0;
  endtask

  function automatic in_t rnd_in();
    in_t v;
    v.stall   = ($urandom_range(3) == 0);
    v.flush   = ($urandom_range(9) == 0);
    v.valid   = ($urandom_range(3) != 0);
    v.pc      = $urandom;
    v.rs_data = $urandom;
    v.rt_data = $urandom;
    v.imm     = $urandom;
    v.rs_addr = 5'($urandom_range(3));
    v.rt_addr = 5'($urandom_range(3));
    v.rd_addr = 5'($urandom_range(31));
    v.ctrl    = 10'($urandom_range(1023));
    v.wb_we   = ($urandom_range(1) == 1);
    v.wb_addr = 5'($urandom_range(3));
    v.wb_data = $urandom;
    return v;
  endfunction

  initial begin
    in_t  v;
    out_t held;
    out_t e;
    int   sat[5] = '{1, 2, 3, 3, 3};

    add("load_imm",    mk(0,1,32'h4,5,0,32'hFFFF8000,0,0,0,10'h010,0,0,0),
                       mo(1,32'h4,5,0,32'hFFFF8000,0,0,0,10'h010,0));
    add("byp_rs",      mk(0,1,8,1,2,0,8,1,2,0,1,8,32'hDEADBEEF),
                       mo(1,8,32'hDEADBEEF,2,0,8,1,2,0,0));
    add("byp_r0",      mk(0,1,12,1,2,0,0,0,0,0,1,0,32'hDEADBEEF),
                       mo(1,12,1,2,0,0,0,0,0,0));
    add("byp_both",    mk(0,1,16,10,20,0,3,3,5,10'h208,1,3,55),
                       mo(1,16,55,55,0,3,3,5,10'h208,0));
    add("byp_we_off",  mk(0,1,20,10,20,0,3,3,5,0,0,3,55),
                       mo(1,20,10,20,0,3,3,5,0,0));
    add("byp_rt_only", mk(0,1,24,10,20,0,2,6,0,0,1,6,77),
                       mo(1,24,10,77,0,2,6,0,0,0));
    add("invalid_in",  mk(0,0,100,7,8,9,1,2,3,10'h240,0,0,0),
                       mo(0,100,7,8,9,1,2,3,0,0));
    add("flush",       mk(1,1,4,1,1,1,1,1,1,10'h3FF,0,0,0),
                       mo(0,0,0,0,0,0,0,0,0,1));
    add("post_flush",  mk(0,1,32'h8,11,12,32'h7FFF,4,5,31,10'h3FF,0,0,0),
                       mo(1,8,11,12,32'h7FFF,4,5,31,10'h3FF,1));

    // Busy inputs during reset must not leak into the stage.
    drive(mk(0,1,32'h44,3,4,5,1,2,3,10'h3FF,1,1,9));
    async_reset("reset");

    foreach (tbl[k]) begin
      cycle(tbl[k].i);
      check(tbl[k].n, tbl[k].e);
    end

    // Stall for three cycles; only the WB write to the held rt register may change anything.
    v = mk(0,1,32'h40,2,1,32'h1234,4,9,7,10'h2A5,0,0,0);
    cycle(v);
    held = mo(1,32'h40,2,1,32'h1234,4,9,7,10'h2A5,1);
    check("stall_load", held);
    v = rnd_in(); v.stall = 1'b1; v.flush = 1'b0; v.wb_we = 1'b0;
    cycle(v);
    check("stall_c1", held);
    v = rnd_in(); v.stall = 1'b1; v.flush = 1'b0; v.wb_we = 1'b1; v.wb_addr = 5'd9; v.wb_data = 7;
    cycle(v);
    held.rt_data = 7;
    check("stall_c2_wb", held);
    v = rnd_in(); v.stall = 1'b1; v.flush = 1'b0; v.wb_we = 1'b1; v.wb_addr = 5'd0; v.wb_data = 99;
    cycle(v);
    check("stall_c3_r0", held);

    v = rnd_in(); v.stall = 1'b1; v.flush = 1'b1;
    cycle(v);
    check("flush_beats_stall", mo(0,0,0,0,0,0,0,0,0,2));

    async_reset("reset_cnt");
    for (int k = 0; k < 5; k++) begin
      cycle(mk(1,1,32'h10,1,2,3,1,2,3,10'h3FF,0,0,0));
      e = '0;
      e.cnt = CW'(sat[k]);
      check($sformatf("sat_%0d", k), e);
    end
    v = mk(0,1,32'h80,5,6,7,1,2,3,10'h1C3,0,0,0);
    cycle(v);
    check("sat_load", mdl);
    v = rnd_in(); v.stall = 1'b1; v.flush = 1'b0;
    cycle(v);
    check("sat_stall", mdl);
    async_reset("reset_mid_stall");
    v = mk(0,1,32'hC0,21,22,23,3,4,5,10'h0F0,0,0,0);
    cycle(v);
    check("first_load", mo(1,32'hC0,21,22,23,3,4,5,10'h0F0,0));

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(49) == 0) begin
        async_reset("rand_reset");
      end else begin
        v = rnd_in();
        cycle(v);
        check("rand", mdl);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
